spi_reg_bank: RTL and testbench

//  SPI-mode-0 slave plus register file feeding pwm_peripheral. Sits between the ui_in pins
//  (nCS/SCLK/COPI) and the PWM block. Decodes 16-bit frames: [15]=R/W (1=write),
//  [14:8]=address, [7:0]=data. Holds the five control registers pwm_peripheral consumes.
//  All SPI pins are asynchronous to clk; sampled via synchronizers, no SCLK clock domain.

---
 rtl/spi_reg_bank.sv | 157 +++++++++++++++
 tb/tb_spi_reg_bank.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 slave feeding the five pwm_peripheral control registers; SPI_READBACK_EN adds read frames on cipo.
// Latency: a valid write frame lands SYNC_STAGES+2 clk after the ncs pin rises.
// Backpressure: none; any frame with >= 2 synced clk of ncs-high gap is taken.
module spi_reg_bank #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ncs,
  input  logic       sclk,
  input  logic       copi,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
  logic                   ncs_hist_q, ncs_hist_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic [15:0]            shift_q, shift_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [7:0]             regs_q [5];
  logic [7:0]             regs_d [5];

  logic ncs_s, sclk_s, copi_s;
  logic ncs_fall, ncs_rise, sclk_rise;
  logic write_ok;

  // The ncs chain resets high so a deasserted bus never looks like a frame start.
  always_comb begin
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
    ncs_s       = ncs_sync_q[SYNC_STAGES-1];
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    copi_s      = copi_sync_q[SYNC_STAGES-1];
    ncs_hist_d  = ncs_s;
    sclk_hist_d = sclk_s;
    ncs_fall    = ncs_hist_q & ~ncs_s;
    ncs_rise    = ~ncs_hist_q & ncs_s;
    sclk_rise   = ~sclk_hist_q & sclk_s;
  end

  assign write_ok = (cnt_q == 5'd16) && shift_q[15] && (shift_q[14:8] <= MAX_ADDR);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 5; i++) regs_d[i] = regs_q[i];
    unique case (state_q)
      ST_IDLE: begin
        if (ncs_fall) begin
          state_d = ST_SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (ncs_rise) begin
          state_d = ST_COMMIT;
        end else if (sclk_rise) begin
          shift_d = {shift_q[14:0], copi_s};
          if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        // Addresses above 0x04 but within MAX_ADDR match no entry and write nothing.
        if (write_ok) begin
          for (int i = 0; i < 5; i++) begin
            if (shift_q[14:8] == 7'(i)) regs_d[i] = shift_q[7:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ncs_sync_q  <= {SYNC_STAGES{1'b1}};
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_hist_q  <= 1'b1;
      sclk_hist_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < 5; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      ncs_sync_q  <= ncs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      copi_sync_q <= copi_sync_d;
      ncs_hist_q  <= ncs_hist_d;
      sclk_hist_q <= sclk_hist_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      for (int i = 0; i < 5; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

`ifdef SPI_READBACK_EN
  logic [7:0] tx_q, tx_d;
  logic [7:0] rd_dat;
  logic       sclk_fall;

  assign sclk_fall = sclk_hist_q & ~sclk_s;

  // Load on the 8th rise; shifting starts on the fall after the 9th rise so the
  // master samples data bit 7 on rise 9 through bit 0 on rise 16.
  always_comb begin
    rd_dat = 8'h00;
    for (int i = 0; i < 5; i++) begin
      if ((shift_d[6:0] == 7'(i)) && (7'(i) <= MAX_ADDR)) rd_dat = regs_q[i];
    end
    tx_d = tx_q;
    if (state_q != ST_SHIFT) begin
      tx_d = 8'h00;
    end else if (sclk_rise && !ncs_rise && (cnt_q == 5'd7)) begin
      tx_d = shift_d[7] ? 8'h00 : rd_dat;
    end else if (sclk_fall && (cnt_q >= 5'd9)) begin
      tx_d = {tx_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_q <= 8'h00;
    else     tx_q <= tx_d;
  end

  assign cipo = (state_q == ST_SHIFT) & tx_q[7];
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: random and directed SPI frames against a register-array model.
module tb_spi_reg_bank;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst, ncs, sclk, copi;
  logic       cipo;
  logic [7:0] o_out_lo, o_out_hi, o_pwm_lo, o_pwm_hi, o_duty;

  always #5 clk = ~clk;

  spi_reg_bank #(.SYNC_STAGES(SYNC), .MAX_ADDR(7'h04)) dut (
    .clk(clk), .rst(rst), .ncs(ncs), .sclk(sclk), .copi(copi), .cipo(cipo),
    .en_reg_out_7_0(o_out_lo), .en_reg_out_15_8(o_out_hi),
    .en_reg_pwm_7_0(o_pwm_lo), .en_reg_pwm_15_8(o_pwm_hi),
    .pwm_duty_cycle(o_duty)
  );

  logic [7:0] dut_regs [5];
  assign dut_regs[0] = o_out_lo;
  assign dut_regs[1] = o_out_hi;
  assign dut_regs[2] = o_pwm_lo;
  assign dut_regs[3] = o_pwm_hi;
  assign dut_regs[4] = o_duty;

  logic [7:0]  mdl [5];
  logic [31:0] rx;
  int checks = 0;
  int failures = 0;

  // A frame writes only when exactly 16 bits arrive, R/W is set and addr <= 4.
  function automatic void model_frame(input logic [31:0] bits, input int n);
    if (n == 16 && bits[15] == 1'b1 && bits[14:8] <= 7'd4) mdl[int'(bits[14:8])] = bits[7:0];
  endfunction

  function automatic logic [7:0] model_read(input logic [6:0] addr);
    if (addr <= 7'd4) return mdl[int'(addr)];
    return 8'h00;
  endfunction

  task automatic shift_bits(input logic [31:0] bits, input int n, input int half);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      copi = bits[i];
      repeat (half) @(negedge clk);
      rx = {rx[30:0], cipo};
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
      for (int r = 0; r < 5; r++) begin
        checks++;
        if (dut_regs[r] !== mdl[r]) begin
          failures++;
          $display("FAIL midframe_stable reg%0d got=%h exp=%h", r, dut_regs[r], mdl[r]);
        end
      end
    end
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n, input int half,
                            input int gap, input bit chk);
    @(negedge clk);
    ncs = 1'b0;
    shift_bits(bits, n, half);
    repeat (half) @(negedge clk);
    ncs = 1'b1;
    if (chk) begin
      repeat (SYNC + 1) @(posedge clk);
      @(negedge clk);
      for (int r = 0; r < 5; r++) begin
        checks++;
        if (dut_regs[r] !== mdl[r]) begin
          failures++;
          $display("FAIL early_update reg%0d got=%h exp=%h", r, dut_regs[r], mdl[r]);
        end
      end
      model_frame(bits, n);
      @(posedge clk);
      @(negedge clk);
      for (int r = 0; r < 5; r++) begin
        checks++;
        if (dut_regs[r] !== mdl[r]) begin
          failures++;
          $display("FAIL commit reg%0d frame=%h bits=%0d got=%h exp=%h", r, bits, n, dut_regs[r], mdl[r]);
        end
      end
    end else begin
      model_frame(bits, n);
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    for (int r = 0; r < 5; r++) mdl[r] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (dut_regs[r] !== 8'h00) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h exp=00", r, dut_regs[r]);
      end
    end
    checks++;
    if (cipo !== 1'b0) begin
      failures++;
      $display("FAIL reset_cipo got=%b exp=0", cipo);
    end
  endtask

  task automatic test_write_latency();
    send_frame(32'h80F0, 16, 4, 4, 1'b1);
    checks++;
    if (o_out_lo !== 8'hF0) begin
      failures++;
      $display("FAIL first_write got=%h exp=f0", o_out_lo);
    end
  endtask

  task automatic test_all_regs();
    send_frame(32'h8155, 16, 4, 4, 1'b1);
    send_frame(32'h82AA, 16, 4, 4, 1'b1);
    send_frame(32'h8301, 16, 4, 4, 1'b1);
    send_frame(32'h8480, 16, 4, 4, 1'b1);
    send_frame(32'h85FF, 16, 4, 4, 1'b1);
    checks++;
    if ({o_out_hi, o_pwm_lo, o_pwm_hi, o_duty} !== 32'h55AA0180) begin
      failures++;
      $display("FAIL all_regs got=%h exp=55aa0180", {o_out_hi, o_pwm_lo, o_pwm_hi, o_duty});
    end
  endtask

  task automatic test_bad_length();
    send_frame(32'h80FF >> 1, 15, 4, 4, 1'b1);
    send_frame({15'h0, 16'h80AB, 1'b1}, 17, 4, 4, 1'b1);
  endtask

  task automatic test_read();
    logic [7:0] exp;
`ifdef SPI_READBACK_EN
    exp = 8'h80;
`else
    exp = 8'h00;
`endif
    send_frame(32'h0400, 16, 4, 4, 1'b1);
    checks++;
    if (rx[7:0] !== exp) begin
      failures++;
      $display("FAIL read_reg4 cipo_bits=%h exp=%h", rx[7:0], exp);
    end
    checks++;
    if (cipo !== 1'b0) begin
      failures++;
      $display("FAIL cipo_idle got=%b exp=0", cipo);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      logic        rw;
      logic [6:0]  addr;
      logic [7:0]  dat, exp;
      logic [15:0] frame;
      int          sel;
      rw    = 1'($urandom_range(0, 1));
      addr  = 7'($urandom_range(0, 7));
      dat   = 8'($urandom);
      frame = {rw, addr, dat};
      sel   = $urandom_range(0, 5);
      exp   = model_read(addr);
`ifndef SPI_READBACK_EN
      exp   = 8'h00;
`endif
      if (sel == 0)      send_frame({17'h0, frame[15:1]}, 15, 4, 4, 1'b1);
      else if (sel == 1) send_frame({15'h0, frame, 1'($urandom_range(0, 1))}, 17, 4, 4, 1'b1);
      else begin
        send_frame({16'h0, frame}, 16, 4, 4, 1'b1);
        if (!rw) begin
          checks++;
          if (rx[7:0] !== exp) begin
            failures++;
            $display("FAIL rand_read addr=%h cipo_bits=%h exp=%h", addr, rx[7:0], exp);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    ncs = 1'b0;
    shift_bits(32'h80FF >> 7, 9, 4);
    rst = 1'b1;
    for (int r = 0; r < 5; r++) mdl[r] = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (dut_regs[r] !== 8'h00) begin
        failures++;
        $display("FAIL midframe_reset reg%0d got=%h exp=00", r, dut_regs[r]);
      end
    end
    ncs = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(32'h8011, 16, 4, 4, 1'b1);
    checks++;
    if (o_out_lo !== 8'h11) begin
      failures++;
      $display("FAIL after_reset_write got=%h exp=11", o_out_lo);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(32'h8001, 16, 2, 2, 1'b0);
    send_frame(32'h8103, 16, 2, 2, 1'b0);
    send_frame(32'h8002, 16, 2, 2, 1'b1);
    checks++;
    if ({o_out_lo, o_out_hi} !== 16'h0203) begin
      failures++;
      $display("FAIL back_to_back got=%h exp=0203", {o_out_lo, o_out_hi});
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_latency();
    test_all_regs();
    test_bad_length();
    test_read();
    test_random();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
